// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_pkg
// Brief    : Shared state type and default unlock pattern for the sequence
//            transmitter and the detector bench.
// Revision : 1.0
// ============================================================================
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_DONE  = 2'd3
    } seq_tx_state_t;

    localparam int          SEQ_TX_LEN     = 12;
    localparam logic [11:0] SEQ_TX_PATTERN = 12'b0101_0000_1000;
    localparam int          SEQ_TX_REPEAT  = 2;
    localparam int          SEQ_TX_GUARD   = 2;

endpackage : seq_tx_pkg
`default_nettype wire

// File: rtl/seq_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_transmitter_if
// Brief    : Frame request/abort handshake and serial line of the transmitter.
// Revision : 1.0
// ============================================================================
interface seq_transmitter_if;

    logic start;
    logic abort;
    logic tx;
    logic busy;
    logic done;

    modport master (
        output start,
        output abort,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        output tx,
        output busy,
        output done
    );

endinterface : seq_transmitter_if
`default_nettype wire

// File: rtl/seq_tx_symctr.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_symctr
// Brief    : Bit and repeat counters walking the pattern MSB first.
// Revision : 1.0
// ============================================================================
module seq_tx_symctr #(
    parameter int PATTERN_LEN = 12,
    parameter int REPEAT      = 2,
    parameter int BW          = 4,
    parameter int CW          = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_load,
    input  wire logic          i_step,
    output logic [BW-1:0]      o_bit_idx,
    output logic               o_last_rep,
    output logic               o_last_bit
);

    localparam int c_FIRST_BIT = PATTERN_LEN - 1;
    localparam int c_LAST_REP  = REPEAT - 1;

    logic [BW-1:0] r_bit;
    logic [CW-1:0] r_rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit <= '0;
            r_rep <= '0;
        end else if (i_load) begin
            r_bit <= c_FIRST_BIT[BW-1:0];
            r_rep <= '0;
        end else if (i_step) begin
            if (o_last_rep) begin
                r_rep <= '0;
                // Bit index holds at 0 so it never wraps past the last bit
                if (!o_last_bit) begin
                    r_bit <= r_bit - BW'(1);
                end
            end else begin
                r_rep <= r_rep + CW'(1);
            end
        end
    end

    assign o_bit_idx  = r_bit;
    assign o_last_rep = (r_rep == c_LAST_REP[CW-1:0]);
    assign o_last_bit = (r_bit == '0);

endmodule : seq_tx_symctr
`default_nettype wire

// File: rtl/seq_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : seq_transmitter
// Brief    : Serial unlock-sequence transmitter: repeated pattern bits, guard
//            zeros, then a one-cycle done pulse.
// Revision : 1.0
// ============================================================================
module seq_transmitter
    import seq_tx_pkg::*;
#(
    parameter int                     PATTERN_LEN = SEQ_TX_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = SEQ_TX_PATTERN,
    parameter int                     REPEAT      = SEQ_TX_REPEAT,
    parameter int                     GUARD       = SEQ_TX_GUARD
) (
    input  wire logic          clk,
    input  wire logic          RESET,
    seq_transmitter_if.slave   bus
);

    localparam int c_BW   = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam int c_CMAX = (REPEAT > GUARD) ? REPEAT : GUARD;
    localparam int c_CW   = $clog2(c_CMAX + 1);
    localparam int c_GMAX = GUARD - 1;

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_SEND  = ST_SEND;
    localparam logic [1:0] c_ST_GUARD = ST_GUARD;
    localparam logic [1:0] c_ST_DONE  = ST_DONE;

    generate
        if (REPEAT < 1) begin : g_chk_repeat
            $error("seq_transmitter: REPEAT must be >= 1");
        end
        if (GUARD < 1) begin : g_chk_guard
            $error("seq_transmitter: GUARD must be >= 1");
        end
        if (PATTERN_LEN < 1) begin : g_chk_len
            $error("seq_transmitter: PATTERN_LEN must be >= 1");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_guard;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic [c_BW-1:0] w_bit_idx;
    logic [c_BW-1:0] w_next_idx;
    logic            w_last_rep;
    logic            w_last_bit;
    logic            w_load;
    logic            w_step;

    assign w_load     = (r_state == c_ST_IDLE) && bus.start;
    assign w_step     = (r_state == c_ST_SEND) && !bus.abort;
    assign w_next_idx = w_bit_idx - c_BW'(1);

    seq_tx_symctr #(
        .PATTERN_LEN (PATTERN_LEN),
        .REPEAT      (REPEAT),
        .BW          (c_BW),
        .CW          (c_CW)
    ) u_symctr (
        .clk        (clk),
        .rst        (RESET),
        .i_load     (w_load),
        .i_step     (w_step),
        .o_bit_idx  (w_bit_idx),
        .o_last_rep (w_last_rep),
        .o_last_bit (w_last_bit)
    );

    // tx is loaded one step ahead so the line is registered yet shows the
    // first bit in the cycle right after start is sampled
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_guard <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b0;
                    if (bus.start) begin
                        r_state <= c_ST_SEND;
                        r_tx    <= PATTERN[PATTERN_LEN-1];
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_SEND: begin
                    if (bus.abort) begin
                        r_state <= c_ST_IDLE;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_last_rep && w_last_bit) begin
                        r_state <= c_ST_GUARD;
                        r_guard <= '0;
                        r_tx    <= 1'b0;
                    end else if (w_last_rep) begin
                        r_tx <= PATTERN[w_next_idx];
                    end
                end
                c_ST_GUARD: begin
                    r_tx <= 1'b0;
                    if (bus.abort) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_guard == c_GMAX[c_CW-1:0]) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_guard <= r_guard + c_CW'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule : seq_transmitter
`default_nettype wire
